// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, FSM states and
// instruction classes.
package multicycle_control_pkg;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StTrap   = 3'd7;

  typedef enum logic [2:0] {
    ClsR,
    ClsI,
    ClsLoad,
    ClsStore,
    ClsBranch
  } instr_class_e;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode classifier; flags any opcode outside the supported set.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  logic [6:0]   opcode_i,
  output instr_class_e class_o,
  output logic         illegal_o
);

  always_comb begin
    class_o   = ClsR;
    illegal_o = 1'b0;
    case (opcode_i)
      OpcR:      class_o = ClsR;
      OpcI:      class_o = ClsI;
      OpcLoad:   class_o = ClsLoad;
      OpcStore:  class_o = ClsStore;
      OpcBranch: class_o = ClsBranch;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 datapath, with
// memory-wait timeout trap and retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned INSTRET_WIDTH = 32,
  parameter int unsigned MEM_TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     funct7_5,
  input  logic                     selectedFlag,
  input  logic                     memReady,
  output logic                     irLoad,
  output logic                     pcWrite,
  output logic                     pcSelectBranch,
  output logic                     writeEnable_Registers,
  output logic                     writeEnable_DataMemory,
  output logic                     muxSelect_ImmVsDataout2,
  output logic                     muxSelect_SumVsReadData,
  output logic                     SumOrSub,
  output logic [2:0]               state,
  output logic                     illegal,
  output logic [INSTRET_WIDTH-1:0] instret
);

  logic [2:0]               state_q, state_d;
  instr_class_e             class_q, class_d;
  logic                     f75_q, f75_d;
  logic [7:0]               tmo_q, tmo_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
  logic                     illegal_q, illegal_d;

  instr_class_e dec_class;
  logic         dec_illegal;
  logic         unused_funct3;

  assign unused_funct3 = ^funct3;

  multicycle_control_decode u_decode (
    .opcode_i  (opcode),
    .class_o   (dec_class),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    f75_d     = f75_q;
    tmo_d     = tmo_q;
    instret_d = instret_q;
    illegal_d = illegal_q;

    irLoad                  = 1'b0;
    pcWrite                 = 1'b0;
    pcSelectBranch          = 1'b0;
    writeEnable_Registers   = 1'b0;
    writeEnable_DataMemory  = 1'b0;
    muxSelect_ImmVsDataout2 = 1'b0;
    muxSelect_SumVsReadData = 1'b0;
    SumOrSub                = 1'b0;

    // Operand/ALU selects stay stable from EXEC to the instruction's last cycle.
    if (state_q inside {StExec, StMem, StWb}) begin
      muxSelect_ImmVsDataout2 = class_q inside {ClsI, ClsLoad, ClsStore};
      SumOrSub = (class_q == ClsR) ? f75_q : (class_q == ClsBranch);
    end

    case (state_q)
      StFetch: begin
        irLoad = run;
        if (run) state_d = StDecode;
      end
      StDecode: begin
        class_d = dec_class;
        f75_d   = funct7_5;
        if (dec_illegal) begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (class_q == ClsBranch) begin
          pcWrite        = 1'b1;
          pcSelectBranch = selectedFlag;
          instret_d      = instret_q + INSTRET_WIDTH'(1);
          state_d        = StFetch;
        end else if (class_q inside {ClsLoad, ClsStore}) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        writeEnable_DataMemory  = (class_q == ClsStore);
        muxSelect_SumVsReadData = (class_q == ClsLoad);
        if (memReady) begin
          tmo_d = '0;
          if (class_q == ClsStore) begin
            pcWrite   = 1'b1;
            instret_d = instret_q + INSTRET_WIDTH'(1);
            state_d   = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (tmo_q == 8'(MEM_TIMEOUT - 1)) begin
          tmo_d     = '0;
          state_d   = StTrap;
          illegal_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StWb: begin
        writeEnable_Registers   = 1'b1;
        pcWrite                 = 1'b1;
        muxSelect_SumVsReadData = (class_q == ClsLoad);
        instret_d               = instret_q + INSTRET_WIDTH'(1);
        state_d                 = StFetch;
      end
      StTrap: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      class_q   <= ClsR;
      f75_q     <= 1'b0;
      tmo_q     <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      f75_q     <= f75_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control with hand-computed per-cycle
// state and control-output expectations.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset, run, funct7_5, selectedFlag, memReady;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        irLoad, pcWrite, pcSelectBranch, writeEnable_Registers;
  logic        writeEnable_DataMemory, muxSelect_ImmVsDataout2;
  logic        muxSelect_SumVsReadData, SumOrSub, illegal;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [7:0]  outs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control #(
    .INSTRET_WIDTH (32),
    .MEM_TIMEOUT   (15)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .run                     (run),
    .opcode                  (opcode),
    .funct3                  (funct3),
    .funct7_5                (funct7_5),
    .selectedFlag            (selectedFlag),
    .memReady                (memReady),
    .irLoad                  (irLoad),
    .pcWrite                 (pcWrite),
    .pcSelectBranch          (pcSelectBranch),
    .writeEnable_Registers   (writeEnable_Registers),
    .writeEnable_DataMemory  (writeEnable_DataMemory),
    .muxSelect_ImmVsDataout2 (muxSelect_ImmVsDataout2),
    .muxSelect_SumVsReadData (muxSelect_SumVsReadData),
    .SumOrSub                (SumOrSub),
    .state                   (state),
    .illegal                 (illegal),
    .instret                 (instret)
  );

  // Bit order: irLoad pcWrite pcSel weReg weDM imm rdData sub
  assign outs = {irLoad, pcWrite, pcSelectBranch, writeEnable_Registers,
                 writeEnable_DataMemory, muxSelect_ImmVsDataout2,
                 muxSelect_SumVsReadData, SumOrSub};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are set just after a falling edge; sample 1ns later, then advance a cycle.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] o);
    #1;
    check_eq({tag, "/state"}, 64'(state), 64'(st));
    check_eq({tag, "/outs"}, 64'(outs), 64'(o));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    selectedFlag = 1'b0; memReady = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc("rst", 3'd0, 8'b0000_0000);
    check_eq("rst/instret", 64'(instret), 64'd0);
    check_eq("rst/illegal", 64'(illegal), 64'd0);

    // ADD
    run = 1'b1; opcode = 7'b0110011; funct7_5 = 1'b0;
    cyc("add_f", 3'd0, 8'b1000_0000);
    cyc("add_d", 3'd1, 8'b0000_0000);
    cyc("add_e", 3'd2, 8'b0000_0000);
    cyc("add_w", 3'd4, 8'b0101_0000);
    // SUB
    funct7_5 = 1'b1;
    cyc("sub_f", 3'd0, 8'b1000_0000);
    cyc("sub_d", 3'd1, 8'b0000_0000);
    funct7_5 = 1'b0;
    cyc("sub_e", 3'd2, 8'b0000_0001);
    cyc("sub_w", 3'd4, 8'b0101_0001);
    #1 check_eq("alu/instret", 64'(instret), 64'd2);

    // LD with two wait cycles
    opcode = 7'b0000011; memReady = 1'b1;
    cyc("ld_f", 3'd0, 8'b1000_0000);
    cyc("ld_d", 3'd1, 8'b0000_0000);
    cyc("ld_e", 3'd2, 8'b0000_0100);
    memReady = 1'b0;
    cyc("ld_m1", 3'd3, 8'b0000_0110);
    cyc("ld_m2", 3'd3, 8'b0000_0110);
    memReady = 1'b1;
    cyc("ld_m3", 3'd3, 8'b0000_0110);
    cyc("ld_w", 3'd4, 8'b0101_0110);
    #1 check_eq("ld/instret", 64'(instret), 64'd3);

    // SD, ready on first MEM cycle
    opcode = 7'b0100011;
    cyc("sd_f", 3'd0, 8'b1000_0000);
    cyc("sd_d", 3'd1, 8'b0000_0000);
    cyc("sd_e", 3'd2, 8'b0000_0100);
    cyc("sd_m", 3'd3, 8'b0100_1100);
    #1 check_eq("sd/instret", 64'(instret), 64'd4);

    // BEQ taken then not taken; flag toggled outside EXEC must not matter
    opcode = 7'b1100011; selectedFlag = 1'b0;
    cyc("bt_f", 3'd0, 8'b1000_0000);
    cyc("bt_d", 3'd1, 8'b0000_0000);
    selectedFlag = 1'b1;
    cyc("bt_e", 3'd2, 8'b0110_0001);
    cyc("bn_f", 3'd0, 8'b1000_0000);
    cyc("bn_d", 3'd1, 8'b0000_0000);
    selectedFlag = 1'b0;
    cyc("bn_e", 3'd2, 8'b0100_0001);
    #1 check_eq("br/instret", 64'(instret), 64'd6);

    // ADDI
    opcode = 7'b0010011;
    cyc("addi_f", 3'd0, 8'b1000_0000);
    cyc("addi_d", 3'd1, 8'b0000_0000);
    cyc("addi_e", 3'd2, 8'b0000_0100);
    cyc("addi_w", 3'd4, 8'b0101_0100);
    #1 check_eq("addi/instret", 64'(instret), 64'd7);

    // Illegal opcode traps after DECODE
    opcode = 7'b1111111;
    cyc("ill_f", 3'd0, 8'b1000_0000);
    cyc("ill_d", 3'd1, 8'b0000_0000);
    cyc("ill_t1", 3'd7, 8'b0000_0000);
    cyc("ill_t2", 3'd7, 8'b0000_0000);
    #1 check_eq("ill/illegal", 64'(illegal), 64'd1);
    check_eq("ill/instret", 64'(instret), 64'd7);
    do_reset();
    cyc("ill_rst", 3'd0, 8'b1000_0000);
    check_eq("ill_rst/illegal", 64'(illegal), 64'd0);
    check_eq("ill_rst/instret", 64'(instret), 64'd0);

    // Store timeout: 15 MEM cycles with memReady low, then TRAP
    opcode = 7'b0100011; memReady = 1'b0;
    cyc("sto_d", 3'd1, 8'b0000_0000);
    cyc("sto_e", 3'd2, 8'b0000_0100);
    for (int i = 0; i < 15; i++) cyc($sformatf("sto_m%0d", i), 3'd3, 8'b0000_1100);
    memReady = 1'b1;
    cyc("sto_t", 3'd7, 8'b0000_0000);
    #1 check_eq("sto/illegal", 64'(illegal), 64'd1);
    check_eq("sto/instret", 64'(instret), 64'd0);
    do_reset();
    cyc("sto_rst", 3'd0, 8'b1000_0000);
    check_eq("sto_rst/illegal", 64'(illegal), 64'd0);

    // Reset in the middle of a load, run held low afterwards
    opcode = 7'b0000011; memReady = 1'b0;
    cyc("rl_d", 3'd1, 8'b0000_0000);
    cyc("rl_e", 3'd2, 8'b0000_0100);
    reset = 1'b1; run = 1'b0;
    cyc("rl_m", 3'd3, 8'b0000_0110);
    reset = 1'b0;
    cyc("rl_idle1", 3'd0, 8'b0000_0000);
    cyc("rl_idle2", 3'd0, 8'b0000_0000);
    #1 check_eq("rl/instret", 64'(instret), 64'd0);
    check_eq("rl/illegal", 64'(illegal), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
